// File: rtl/axi_regfile_pkg.sv
// rtl/axi_regfile_pkg.sv - shared response codes, register kinds and mask helpers
package axi_regfile_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Widest register map the mask helpers can describe.
    localparam int MAX_REGS = 256;

    typedef enum logic [1:0] {
        REG_RW,
        REG_RO,
        REG_PULSE
    } reg_kind_t;

    // Read-only takes precedence when a register is flagged both RO and PULSE.
    function automatic reg_kind_t reg_kind(
        input int                  i,
        input logic [MAX_REGS-1:0] ro_mask,
        input logic [MAX_REGS-1:0] pulse_mask
    );
        if (ro_mask[i]) return REG_RO;
        if (pulse_mask[i]) return REG_PULSE;
        return REG_RW;
    endfunction

    // Expands a byte-strobe vector into a bit mask; callers truncate to their data width.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_lite_slot.sv
// rtl/axi_lite_slot.sv - single-entry holding register for one AXI4-Lite channel
// Ports: in_valid/in_ready/in_data accept a beat while empty; full/data present it;
//        clear empties the slot once the consumer has used it.
module axi_lite_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         clear,
    output logic         full,
    output logic [W-1:0] data
);

    assign in_ready = !full;

    // Capture only happens while empty and clear only while full, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            data <= '0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            data <= in_data;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_regfile_gen.sv
// rtl/axi_regfile_gen.sv - parametrised AXI4-Lite slave register file with RW/RO/PULSE registers
// Ports: S_AXI_* standard AXI4-Lite slave; slv_reg stored register values;
//        slv_read status inputs for RO registers; slv_wr_pulse / slv_rd_pulse per-register strobes.
module axi_regfile_gen
    import axi_regfile_pkg::*;
#(
    parameter int                  C_S_AXI_DATA_WIDTH = 32,
    parameter int                  C_S_AXI_ADDR_WIDTH = 8,
    parameter int                  NUM_REGS           = 32,
    parameter logic [NUM_REGS-1:0] RO_MASK            = '0,
    parameter logic [NUM_REGS-1:0] PULSE_MASK         = '0
) (
    input  logic                                     S_AXI_ACLK,
    input  logic                                     S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                               S_AXI_AWPROT,
    input  logic                                     S_AXI_AWVALID,
    output logic                                     S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]          S_AXI_WSTRB,
    input  logic                                     S_AXI_WVALID,
    output logic                                     S_AXI_WREADY,
    output logic [1:0]                               S_AXI_BRESP,
    output logic                                     S_AXI_BVALID,
    input  logic                                     S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                               S_AXI_ARPROT,
    input  logic                                     S_AXI_ARVALID,
    output logic                                     S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]            S_AXI_RDATA,
    output logic [1:0]                               S_AXI_RRESP,
    output logic                                     S_AXI_RVALID,
    input  logic                                     S_AXI_RREADY,
    output logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_reg,
    input  logic [NUM_REGS-1:0][C_S_AXI_DATA_WIDTH-1:0] slv_read,
    output logic [NUM_REGS-1:0]                      slv_wr_pulse,
    output logic [NUM_REGS-1:0]                      slv_rd_pulse
);

    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int AW  = C_S_AXI_ADDR_WIDTH;
    localparam int SW  = DW / 8;
    localparam int LSB = (DW == 64) ? 3 : 2;
    localparam int IW  = AW - LSB;

    localparam logic [MAX_REGS-1:0] RO_EXT     = MAX_REGS'(RO_MASK);
    localparam logic [MAX_REGS-1:0] PULSE_EXT  = MAX_REGS'(PULSE_MASK);
    localparam logic [IW:0]         NUM_REGS_W = (IW + 1)'(NUM_REGS);

    if (DW != 32 && DW != 64) begin : g_bad_dw
        $error("axi_regfile_gen: C_S_AXI_DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > MAX_REGS || NUM_REGS > (1 << IW)) begin : g_bad_regs
        $error("axi_regfile_gen: NUM_REGS does not fit the address space");
    end

    // Readies stay low through reset and rise on the first clock edge after release.
    logic rdy_en;
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) rdy_en <= 1'b0;
        else                rdy_en <= 1'b1;
    end

    // Write address / data slots
    logic          aw_full, aw_in_ready, w_full, w_in_ready, commit;
    logic [IW-1:0] aw_idx;
    logic [SW-1:0] w_strb;
    logic [DW-1:0] w_data;

    axi_lite_slot #(.W(IW)) u_aw_slot (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .in_valid (S_AXI_AWVALID & rdy_en),
        .in_ready (aw_in_ready),
        .in_data  (S_AXI_AWADDR[AW-1:LSB]),
        .clear    (commit),
        .full     (aw_full),
        .data     (aw_idx)
    );

    axi_lite_slot #(.W(SW + DW)) u_w_slot (
        .clk      (S_AXI_ACLK),
        .rst_n    (S_AXI_ARESETN),
        .in_valid (S_AXI_WVALID & rdy_en),
        .in_ready (w_in_ready),
        .in_data  ({S_AXI_WSTRB, S_AXI_WDATA}),
        .clear    (commit),
        .full     (w_full),
        .data     ({w_strb, w_data})
    );

    assign S_AXI_AWREADY = rdy_en & aw_in_ready;
    assign S_AXI_WREADY  = rdy_en & w_in_ready;

    // Write decode
    logic                aw_in_range;
    logic [DW-1:0]       wr_mask;
    logic [NUM_REGS-1:0] wr_sel;

    assign commit      = aw_full & w_full & (!S_AXI_BVALID | S_AXI_BREADY);
    assign aw_in_range = {1'b0, aw_idx} < NUM_REGS_W;
    assign wr_mask     = DW'(strb_to_mask(8'(w_strb)));
    assign wr_sel      = (commit && aw_in_range) ? (NUM_REGS'(1) << aw_idx) : '0;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
            slv_wr_pulse <= '0;
        end else begin
            slv_wr_pulse <= wr_sel;
            if (commit) begin
                S_AXI_BVALID <= 1'b1;
                S_AXI_BRESP  <= aw_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                S_AXI_BVALID <= 1'b0;
            end
        end
    end

    // Per-register storage; RO registers keep their storage at zero.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        localparam reg_kind_t KIND = reg_kind(i, RO_EXT, PULSE_EXT);
        logic [DW-1:0] reg_q;
        always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
            if (!S_AXI_ARESETN) begin
                reg_q <= '0;
            end else if (KIND == REG_PULSE) begin
                // Shows the masked write for exactly one cycle, never merges with old data.
                reg_q <= wr_sel[i] ? (w_data & wr_mask) : '0;
            end else if (KIND == REG_RW && wr_sel[i]) begin
                reg_q <= (reg_q & ~wr_mask) | (w_data & wr_mask);
            end
        end
        assign slv_reg[i] = reg_q;
    end

    // Read path: the mux sees pre-commit storage, so a same-cycle write is not visible.
    logic [IW-1:0] ar_idx;
    logic          ar_in_range, ar_hs;
    logic [DW-1:0] rd_mux;

    assign ar_idx        = S_AXI_ARADDR[AW-1:LSB];
    assign ar_in_range   = {1'b0, ar_idx} < NUM_REGS_W;
    assign S_AXI_ARREADY = rdy_en & (!S_AXI_RVALID | S_AXI_RREADY);
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ar_idx == IW'(i)) begin
                case (reg_kind(i, RO_EXT, PULSE_EXT))
                    REG_RW:  rd_mux = slv_reg[i];
                    REG_RO:  rd_mux = slv_read[i];
                    default: rd_mux = '0;
                endcase
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
            slv_rd_pulse <= '0;
        end else begin
            slv_rd_pulse <= '0;
            if (ar_hs) begin
                S_AXI_RVALID <= 1'b1;
                S_AXI_RDATA  <= rd_mux;
                S_AXI_RRESP  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
                if (ar_in_range) slv_rd_pulse <= NUM_REGS'(1) << ar_idx;
            end else if (S_AXI_RREADY) begin
                S_AXI_RVALID <= 1'b0;
            end
        end
    end

    // Protection bits and byte offsets carry no meaning for this register file.
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[LSB-1:0],
                           S_AXI_ARADDR[LSB-1:0], slv_read};

endmodule

// File: tb/tb_axi_regfile_gen.sv
// tb/tb_axi_regfile_gen.sv - scoreboard testbench for axi_regfile_gen
module tb_axi_regfile_gen;

    localparam int NR = 8;
    localparam logic [1:0] OK = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_ARVALID = 0;
    logic        S_AXI_BREADY = 1, S_AXI_RREADY = 1;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic [NR-1:0][31:0] slv_reg, slv_read;
    logic [NR-1:0] slv_wr_pulse, slv_rd_pulse;

    axi_regfile_gen #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_REGS(NR),
        .RO_MASK(8'h01), .PULSE_MASK(8'h08)
    ) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .slv_reg(slv_reg), .slv_read(slv_read),
        .slv_wr_pulse(slv_wr_pulse), .slv_rd_pulse(slv_rd_pulse)
    );

    typedef struct { logic [31:0] data; logic [1:0] resp; } rexp_t;
    logic [1:0]  exp_b[$];
    rexp_t       exp_r[$];
    logic [31:0] mem[NR];
    int n_checks = 0, n_pass = 0;
    int wr_cnt[NR], rd_cnt[NR];
    int pulse_nz = 0;
    logic [31:0] pulse_val = '0;
    logic [1:0]  b_e;
    rexp_t       r_e;
    logic [7:0]  burst_addr[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    endtask

    // Scoreboard monitor: pops one expectation per completed response beat.
    always @(negedge clk) begin
        if (rst_n) begin
            if (S_AXI_BVALID && S_AXI_BREADY) begin
                if (exp_b.size() == 0) chk("b_unexpected", 1, 0);
                else begin
                    b_e = exp_b.pop_front();
                    chk("bresp", S_AXI_BRESP, b_e);
                end
            end
            if (S_AXI_RVALID && S_AXI_RREADY) begin
                if (exp_r.size() == 0) chk("r_unexpected", 1, 0);
                else begin
                    r_e = exp_r.pop_front();
                    chk("rdata", S_AXI_RDATA, r_e.data);
                    chk("rresp", S_AXI_RRESP, r_e.resp);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (slv_wr_pulse[i]) wr_cnt[i]++;
            if (slv_rd_pulse[i]) rd_cnt[i]++;
        end
        if (slv_reg[3] != 0) begin
            pulse_nz++;
            pulse_val = slv_reg[3];
        end
    end

    function automatic bit is_rw(input int idx);
        return idx > 0 && idx < NR && idx != 3;
    endfunction

    function automatic rexp_t exp_read(input logic [7:0] a);
        int idx = int'(a >> 2);
        rexp_t r;
        r.resp = OK;
        if (idx >= NR) begin r.data = '0; r.resp = SLVERR; end
        else if (idx == 0) r.data = slv_read[0];
        else if (idx == 3) r.data = '0;
        else r.data = mem[idx];
        return r;
    endfunction

    function automatic int sum(input int c[NR]);
        int s = 0;
        for (int i = 0; i < NR; i++) s += c[i];
        return s;
    endfunction

    task automatic send_aw(input logic [7:0] a);
        int n = 0; bit hs = 0;
        S_AXI_AWADDR = a; S_AXI_AWVALID = 1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = S_AXI_AWREADY;
            @(posedge clk); #1; n++;
        end
        S_AXI_AWVALID = 0;
        if (!hs) chk("aw_timeout", 0, 1);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n = 0; bit hs = 0;
        S_AXI_WDATA = d; S_AXI_WSTRB = s; S_AXI_WVALID = 1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = S_AXI_WREADY;
            @(posedge clk); #1; n++;
        end
        S_AXI_WVALID = 0;
        if (!hs) chk("w_timeout", 0, 1);
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx = int'(a >> 2);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{s[b]}};
        exp_b.push_back(idx < NR ? OK : SLVERR);
        if (is_rw(idx)) mem[idx] = (mem[idx] & ~m) | (d & m);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    task automatic axi_read(input logic [7:0] a);
        int n = 0; bit hs = 0;
        exp_r.push_back(exp_read(a));
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
        while (!hs && n < 50) begin
            @(negedge clk); hs = S_AXI_ARREADY;
            @(posedge clk); #1; n++;
        end
        S_AXI_ARVALID = 0;
        if (!hs) chk("ar_timeout", 0, 1);
    endtask

    task automatic read_burst(output int cycles);
        int k = 0; bit hs;
        cycles = 0;
        S_AXI_ARADDR = burst_addr[0]; S_AXI_ARVALID = 1;
        exp_r.push_back(exp_read(burst_addr[0]));
        while (k < 8 && cycles < 100) begin
            @(negedge clk); hs = S_AXI_ARREADY;
            @(posedge clk); #1; cycles++;
            if (hs) begin
                k++;
                if (k < 8) begin
                    S_AXI_ARADDR = burst_addr[k];
                    exp_r.push_back(exp_read(burst_addr[k]));
                end else S_AXI_ARVALID = 0;
            end
        end
        if (k < 8) chk("burst_timeout", k, 8);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_b.size() != 0 || exp_r.size() != 0) && n < 200) begin
            @(posedge clk); n++;
        end
        @(posedge clk); #1;
        chk("drain", 64'(exp_b.size() + exp_r.size()), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int snap, snap2, cyc;
        logic [NR-1:0][31:0] reg_snap;
        logic [31:0] hold;
        for (int i = 0; i < NR; i++) begin
            slv_read[i] = 32'hA5A50000 | i; mem[i] = '0; wr_cnt[i] = 0; rd_cnt[i] = 0;
        end
        slv_read[0] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", S_AXI_AWREADY, 0);
        chk("rst_wready", S_AXI_WREADY, 0);
        chk("rst_arready", S_AXI_ARREADY, 0);
        chk("rst_bvalid", S_AXI_BVALID, 0);
        chk("rst_rvalid", S_AXI_RVALID, 0);
        chk("rst_rdata", S_AXI_RDATA, 0);
        chk("rst_slv_reg", slv_reg, 0);
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk); chk("awready_before_edge", S_AXI_AWREADY, 0);
        @(negedge clk); chk("awready_after_edge", S_AXI_AWREADY, 1);
        @(posedge clk); #1;

        // Reset mid-write: AW captured, W never sent
        send_aw(8'h04);
        rst_n = 0;
        @(negedge clk); chk("midrst_awready", S_AXI_AWREADY, 0);
        @(posedge clk); #1; rst_n = 1;
        @(negedge clk); @(negedge clk);
        chk("postrst_bvalid", S_AXI_BVALID, 0);
        chk("postrst_awready", S_AXI_AWREADY, 1);
        chk("postrst_reg1", slv_reg[1], 0);
        @(posedge clk); #1;
        send_w(32'h00001234, 4'hF);
        repeat (4) @(negedge clk);
        chk("w_only_no_commit", S_AXI_BVALID, 0);
        chk("w_only_reg1", slv_reg[1], 0);
        @(posedge clk); #1;
        exp_b.push_back(OK); mem[1] = 32'h00001234;
        send_aw(8'h04);
        wait_idle();
        chk("reg1_after_aw", slv_reg[1], 32'h00001234);

        // RW byte strobes on reg 2
        axi_write(8'h08, 32'h11223344, 4'hF);
        wait_idle();
        snap = wr_cnt[2];
        axi_write(8'h08, 32'hAABBCCDD, 4'b0101);
        wait_idle();
        chk("strb_reg2", slv_reg[2], 32'h11BB33DD);
        chk("wr_pulse2_one_cycle", wr_cnt[2] - snap, 1);
        snap = rd_cnt[2];
        axi_read(8'h08);
        wait_idle();
        chk("rd_pulse2_one_cycle", rd_cnt[2] - snap, 1);

        // W three cycles ahead of AW, BREADY held low
        S_AXI_BREADY = 0;
        send_w(32'hCAFE0004, 4'hF);
        repeat (3) @(posedge clk); #1;
        exp_b.push_back(OK); mem[4] = 32'hCAFE0004;
        send_aw(8'h10);
        fork axi_write(8'h14, 32'hCAFE0005, 4'hF); join_none
        repeat (2) @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("b_held_valid", S_AXI_BVALID, 1);
            chk("b_held_resp", S_AXI_BRESP, OK);
        end
        chk("aw2_stalled", S_AXI_AWREADY, 0);
        chk("reg5_not_committed", slv_reg[5], 0);
        chk("reg4_committed", slv_reg[4], 32'hCAFE0004);
        @(posedge clk); #1; S_AXI_BREADY = 1;
        wait_idle();
        chk("reg5_committed", slv_reg[5], 32'hCAFE0005);

        // RO register 0
        axi_read(8'h00);
        snap = wr_cnt[0];
        axi_write(8'h00, 32'h12345678, 4'hF);
        wait_idle();
        chk("ro_wr_pulse", wr_cnt[0] - snap, 1);
        chk("ro_storage", slv_reg[0], 0);
        axi_read(8'h00);
        wait_idle();

        // PULSE register 3
        snap = pulse_nz;
        axi_write(8'h0C, 32'h00000005, 4'hF);
        wait_idle();
        chk("pulse_cycles", pulse_nz - snap, 1);
        chk("pulse_value", pulse_val, 32'h5);
        chk("pulse_cleared", slv_reg[3], 0);
        axi_write(8'h0C, 32'h00000003, 4'hF);
        wait_idle();
        chk("pulse_no_accum", pulse_val, 32'h3);
        axi_read(8'h0C);
        wait_idle();

        // Out-of-range index NR
        reg_snap = slv_reg; snap = sum(wr_cnt); snap2 = sum(rd_cnt);
        axi_write(8'h20, 32'hFFFFFFFF, 4'hF);
        axi_read(8'h20);
        wait_idle();
        chk("oor_no_change", slv_reg, reg_snap);
        chk("oor_no_wr_pulse", sum(wr_cnt) - snap, 0);
        chk("oor_no_rd_pulse", sum(rd_cnt) - snap2, 0);

        // Back-to-back reads
        axi_write(8'h18, 32'h66666666, 4'hF);
        axi_write(8'h1C, 32'h77777777, 4'hF);
        wait_idle();
        burst_addr = '{8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h1C, 8'h00, 8'h0C};
        read_burst(cyc);
        chk("burst_cycles", cyc, 8);
        wait_idle();
        fork
            read_burst(cyc);
            begin
                repeat (3) @(posedge clk); #1; S_AXI_RREADY = 0;
                @(negedge clk); hold = S_AXI_RDATA;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("r_hold_valid", S_AXI_RVALID, 1);
                    chk("r_hold_data", S_AXI_RDATA, hold);
                end
                @(posedge clk); #1; S_AXI_RREADY = 1;
            end
        join
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
